pipe_hazard_ctrl: RTL and testbench

- Backward-flowing control for the pipelined core; the counterpart to the forward-moving stage registers (fetch→decode, decode→activate, activate→writeback).
- Observes per-stage valid, register-address and memory-access state.
- Drives back into the pipeline:
  - per-register hold enables and flushes;
  - operand forwarding selects;
  - registered PC redirect.
- Contains a data-cache wait FSM and a post-branch squash counter.

---
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stages (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned PC_SIZE    = 16,
    parameter int unsigned REG_ADDR_W = 3
);
    localparam int unsigned FWD_W = 2;

    logic                  d_valid;
    logic [REG_ADDR_W-1:0] d_src0_addr;
    logic [REG_ADDR_W-1:0] d_src1_addr;
    logic                  d_src0_used;
    logic                  d_src1_used;
    logic                  a_valid;
    logic                  a_reg_write;
    logic [REG_ADDR_W-1:0] a_reg_addr;
    logic                  a_mem_access;
    logic                  w_valid;
    logic                  w_reg_write;
    logic [REG_ADDR_W-1:0] w_reg_addr;
    logic                  dc_done;
    logic                  br_taken;
    logic [PC_SIZE-1:0]    br_target;

    logic                  fetch_en;
    logic                  i2d_en;
    logic                  d2a_en;
    logic                  i2d_flush;
    logic                  d2a_flush;
    logic                  a2w_bubble;
    logic [FWD_W-1:0]      fwd_sel0;
    logic [FWD_W-1:0]      fwd_sel1;
    logic                  pc_redirect_valid;
    logic [PC_SIZE-1:0]    pc_redirect;
    logic                  timeout_err;

    modport master (
        output d_valid, d_src0_addr, d_src1_addr, d_src0_used, d_src1_used,
        output a_valid, a_reg_write, a_reg_addr, a_mem_access,
        output w_valid, w_reg_write, w_reg_addr, dc_done, br_taken, br_target,
        input  fetch_en, i2d_en, d2a_en, i2d_flush, d2a_flush, a2w_bubble,
        input  fwd_sel0, fwd_sel1, pc_redirect_valid, pc_redirect, timeout_err
    );

    modport slave (
        input  d_valid, d_src0_addr, d_src1_addr, d_src0_used, d_src1_used,
        input  a_valid, a_reg_write, a_reg_addr, a_mem_access,
        input  w_valid, w_reg_write, w_reg_addr, dc_done, br_taken, br_target,
        output fetch_en, i2d_en, d2a_en, i2d_flush, d2a_flush, a2w_bubble,
        output fwd_sel0, fwd_sel1, pc_redirect_valid, pc_redirect, timeout_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use bubble, d-cache wait FSM, branch squash.
// Optional d-cache timeout enabled by defining PIPE_MEM_TIMEOUT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned PC_SIZE     = 16,
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned    FWD_W   = 2;
    localparam logic [FWD_W-1:0] FWD_RF  = FWD_W'(0);
    localparam logic [FWD_W-1:0] FWD_ACT = FWD_W'(1);
    localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(2);
    localparam int unsigned    SQ_W    = 1;
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SQ_W-1:0]    r_squash_cnt;
    logic               r_pc_redirect_valid;
    logic [PC_SIZE-1:0] r_pc_redirect;

    logic               w_timeout;
    logic               w_mem_stall;
    logic               w_branch;
    logic               w_load_use;
    logic               w_act_fwd_ok;
    logic               w_wb_fwd_ok;
    logic               w_ld_in_act;
    logic               w_fetch_en;
    logic               w_i2d_en;
    logic               w_d2a_en;
    logic               w_i2d_flush;
    logic               w_d2a_flush;
    logic               w_a2w_bubble;
    logic [FWD_W-1:0]   w_fwd_sel0;
    logic [FWD_W-1:0]   w_fwd_sel1;

    // Activate-stage result wins over writeback; loads in activate have no result yet.
    function automatic logic [FWD_W-1:0] fwd_pick(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  act_ok,
        input logic [REG_ADDR_W-1:0] act_addr,
        input logic                  wb_ok,
        input logic [REG_ADDR_W-1:0] wb_addr
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if (used && act_ok && (act_addr == src)) begin
            sel = FWD_ACT;
        end else if (used && wb_ok && (wb_addr == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign w_act_fwd_ok = bus.a_valid & bus.a_reg_write & ~bus.a_mem_access;
    assign w_wb_fwd_ok  = bus.w_valid & bus.w_reg_write;
    assign w_ld_in_act  = bus.a_valid & bus.a_mem_access & bus.a_reg_write;
    assign w_load_use   = bus.d_valid & w_ld_in_act &
                          ((bus.d_src0_used & (bus.a_reg_addr == bus.d_src0_addr)) |
                           (bus.d_src1_used & (bus.a_reg_addr == bus.d_src1_addr)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mem_stall  = 1'b0;
        w_branch     = 1'b0;
        w_fetch_en   = 1'b1;
        w_i2d_en     = 1'b1;
        w_d2a_en     = 1'b1;
        w_i2d_flush  = 1'b0;
        w_d2a_flush  = 1'b0;
        w_a2w_bubble = 1'b0;
        w_fwd_sel0   = fwd_pick(bus.d_src0_used, bus.d_src0_addr, w_act_fwd_ok,
                                bus.a_reg_addr, w_wb_fwd_ok, bus.w_reg_addr);
        w_fwd_sel1   = fwd_pick(bus.d_src1_used, bus.d_src1_addr, w_act_fwd_ok,
                                bus.a_reg_addr, w_wb_fwd_ok, bus.w_reg_addr);

        case (r_state)
            ST_IDLE: begin
                if (bus.a_valid && bus.a_mem_access && !bus.dc_done) begin
                    w_mem_stall = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dc_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_mem_stall = 1'b1;
                    if (w_timeout) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Memory stall freezes everything and masks branch / load-use handling.
        if (w_mem_stall) begin
            w_fetch_en   = 1'b0;
            w_i2d_en     = 1'b0;
            w_d2a_en     = 1'b0;
            w_a2w_bubble = 1'b1;
        end else begin
            w_branch = bus.br_taken & bus.a_valid & (r_squash_cnt == '0);
            if (w_branch) begin
                w_i2d_flush = 1'b1;
                w_d2a_flush = 1'b1;
            end else if (w_load_use) begin
                w_fetch_en  = 1'b0;
                w_i2d_en    = 1'b0;
                w_d2a_flush = 1'b1;
            end
            if (r_squash_cnt != '0) begin
                w_i2d_flush = 1'b1;
            end
        end

        if (rst) begin
            w_state_nxt  = ST_IDLE;
            w_branch     = 1'b0;
            w_fetch_en   = 1'b0;
            w_i2d_en     = 1'b1;
            w_d2a_en     = 1'b1;
            w_i2d_flush  = 1'b0;
            w_d2a_flush  = 1'b0;
            w_a2w_bubble = 1'b0;
            w_fwd_sel0   = FWD_RF;
            w_fwd_sel1   = FWD_RF;
        end
    end

    // Squash counter covers the wrong-path fetch in the cycle after a taken branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_squash_cnt <= '0;
        end else if (w_branch) begin
            r_squash_cnt <= SQ_LOAD;
        end else if (r_squash_cnt != '0) begin
            r_squash_cnt <= r_squash_cnt - SQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_redirect_valid <= 1'b0;
            r_pc_redirect       <= '0;
        end else begin
            r_pc_redirect_valid <= w_branch;
            if (w_branch) begin
                r_pc_redirect <= bus.br_target;
            end
        end
    end

`ifdef PIPE_MEM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    assign w_timeout = (r_state == ST_MEM_WAIT) && !bus.dc_done &&
                       (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

    // Counter sits at zero in IDLE, so it is clear on every MEM_WAIT entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_to_cnt <= '0;
            end else if (!bus.dc_done) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    // MEM_TIMEOUT only matters when the timeout feature is built in.
    logic w_unused_mem_timeout;
    assign w_unused_mem_timeout = (MEM_TIMEOUT == 0);
    assign w_timeout            = 1'b0;
    assign bus.timeout_err      = 1'b0;
`endif

    assign bus.fetch_en          = w_fetch_en;
    assign bus.i2d_en            = w_i2d_en;
    assign bus.d2a_en            = w_d2a_en;
    assign bus.i2d_flush         = w_i2d_flush;
    assign bus.d2a_flush         = w_d2a_flush;
    assign bus.a2w_bubble        = w_a2w_bubble;
    assign bus.fwd_sel0          = w_fwd_sel0;
    assign bus.fwd_sel1          = w_fwd_sel1;
    assign bus.pc_redirect_valid = r_pc_redirect_valid;
    assign bus.pc_redirect       = r_pc_redirect;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed sequences, random vs model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned PC_SIZE     = 16;
    localparam int unsigned REG_ADDR_W  = 3;
    localparam int unsigned MEM_TIMEOUT = 8;
`ifdef PIPE_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // {fetch_en, i2d_en, d2a_en, i2d_flush, d2a_flush, a2w_bubble, fwd_sel0, fwd_sel1}
    localparam logic [9:0] O_NORM  = 10'b1110000000;
    localparam logic [9:0] O_RST   = 10'b0110000000;
    localparam logic [9:0] O_STALL = 10'b0000010000;
    localparam logic [9:0] O_LU    = 10'b0010100000;
    localparam logic [9:0] O_BR    = 10'b1111100000;
    localparam logic [9:0] O_SQ    = 10'b1111000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.PC_SIZE(PC_SIZE), .REG_ADDR_W(REG_ADDR_W)) bus ();

    pipe_hazard_ctrl #(
        .PC_SIZE    (PC_SIZE),
        .REG_ADDR_W (REG_ADDR_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        dv;
        logic [2:0]  s0;
        logic        u0;
        logic [2:0]  s1;
        logic        u1;
        logic        av;
        logic        awr;
        logic [2:0]  aad;
        logic        amem;
        logic        wv;
        logic        wwr;
        logic [2:0]  wad;
        logic        dcd;
        logic        br;
        logic [15:0] tgt;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic in_t mk(logic dv, logic [2:0] s0, logic u0, logic [2:0] s1, logic u1,
                               logic av, logic awr, logic [2:0] aad, logic amem,
                               logic wv, logic wwr, logic [2:0] wad,
                               logic dcd, logic br, logic [15:0] tgt);
        in_t x;
        x.dv = dv; x.s0 = s0; x.u0 = u0; x.s1 = s1; x.u1 = u1;
        x.av = av; x.awr = awr; x.aad = aad; x.amem = amem;
        x.wv = wv; x.wwr = wwr; x.wad = wad;
        x.dcd = dcd; x.br = br; x.tgt = tgt;
        return x;
    endfunction

    task automatic drive(input in_t x);
        bus.d_valid      = x.dv;
        bus.d_src0_addr  = x.s0;
        bus.d_src0_used  = x.u0;
        bus.d_src1_addr  = x.s1;
        bus.d_src1_used  = x.u1;
        bus.a_valid      = x.av;
        bus.a_reg_write  = x.awr;
        bus.a_reg_addr   = x.aad;
        bus.a_mem_access = x.amem;
        bus.w_valid      = x.wv;
        bus.w_reg_write  = x.wwr;
        bus.w_reg_addr   = x.wad;
        bus.dc_done      = x.dcd;
        bus.br_taken     = x.br;
        bus.br_target    = x.tgt;
    endtask

    function automatic logic [9:0] outs();
        return {bus.fetch_en, bus.i2d_en, bus.d2a_en, bus.i2d_flush, bus.d2a_flush,
                bus.a2w_bubble, bus.fwd_sel0, bus.fwd_sel1};
    endfunction

    task automatic sample(input string name, input logic [9:0] eo, input logic erv);
        @(negedge clk);
        chk({name, ".o"}, 32'(outs()), 32'(eo));
        chk({name, ".rv"}, 32'(bus.pc_redirect_valid), 32'(erv));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_fwd(in_t x, logic used, logic [2:0] src);
        if (!used) return 2'd0;
        if (x.av && x.awr && !x.amem && x.aad == src) return 2'd1;
        if (x.wv && x.wwr && x.wad == src) return 2'd2;
        return 2'd0;
    endfunction

    // Reference model state
    bit          m_wait, m_squash, m_rv, m_terr;
    int          m_wcnt;
    logic [15:0] m_rpc;

    vec_t vecs[11];
    in_t  zero, mem, memd;

    initial begin
        zero = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,16'h0);
        mem  = mk(0,0,0,0,0, 1,0,0,1, 0,0,0, 0,0,16'h0);
        memd = mk(0,0,0,0,0, 1,0,0,1, 0,0,0, 1,0,16'h0);

        vecs[0]  = '{"fwd_act",     mk(1,3,1,5,1, 1,1,3,0, 1,1,3, 0,0,16'h0), 10'b1110000100};
        vecs[1]  = '{"fwd_wb",      mk(1,3,1,5,1, 0,1,3,0, 1,1,3, 0,0,16'h0), 10'b1110001000};
        vecs[2]  = '{"fwd_unused",  mk(1,3,0,5,1, 0,1,3,0, 1,1,3, 0,0,16'h0), 10'b1110000000};
        vecs[3]  = '{"fwd_split",   mk(1,6,1,4,1, 1,1,4,0, 1,1,6, 0,0,16'h0), 10'b1110001001};
        vecs[4]  = '{"fwd_no_load", mk(0,2,1,0,0, 1,1,2,1, 1,1,2, 1,0,16'h0), 10'b1110001000};
        vecs[5]  = '{"load_use",    mk(1,0,0,2,1, 1,1,2,1, 0,0,0, 1,0,16'h0), 10'b0010100000};
        vecs[6]  = '{"lu_unused",   mk(1,0,0,2,0, 1,1,2,1, 0,0,0, 1,0,16'h0), 10'b1110000000};
        vecs[7]  = '{"lu_dinv",     mk(0,0,0,2,1, 1,1,2,1, 0,0,0, 1,0,16'h0), 10'b1110000000};
        vecs[8]  = '{"mem_hit",     mk(1,1,1,1,0, 1,0,5,1, 0,0,0, 1,0,16'h0), 10'b1110000000};
        vecs[9]  = '{"wb_nowrite",  mk(1,1,1,7,1, 0,0,0,0, 1,0,1, 0,0,16'h0), 10'b1110000000};
        vecs[10] = '{"fwd_both",    mk(1,5,1,5,1, 1,1,5,0, 1,1,5, 0,0,16'h0), 10'b1110000101};

        // Reset with hazards present: outputs forced, registers cleared
        rst = 1'b1;
        drive(mk(1,3,1,3,1, 1,1,3,1, 1,1,3, 0,1,16'h0055));
        sample("reset", O_RST, 1'b0);
        chk("reset.pc", 32'(bus.pc_redirect), 32'h0);
        chk("reset.terr", 32'(bus.timeout_err), 32'h0);
        adv();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].in);
            @(negedge clk);
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            adv();
        end

        // Load-use bubble lasts one cycle
        drive(vecs[5].in);
        sample("lu_seq0", O_LU, 1'b0);
        adv();
        drive(mk(1,0,0,2,1, 0,0,0,0, 0,0,0, 0,0,16'h0));
        sample("lu_seq1", O_NORM, 1'b0);
        adv();

        // D-cache miss: done arrives 4 cycles later
        drive(mem);
        for (int k = 0; k < 4; k++) begin
            sample($sformatf("memwait%0d", k), O_STALL, 1'b0);
            adv();
        end
        drive(memd);
        sample("mem_release", O_NORM, 1'b0);
        adv();
        drive(zero);
        sample("mem_idle", O_NORM, 1'b0);
        adv();
        drive(memd);
        sample("mem_zero_stall", O_NORM, 1'b0);
        adv();
        drive(zero);
        sample("mem_zero_after", O_NORM, 1'b0);
        adv();

        // Taken branch, second br_taken in N+1 ignored
        drive(mk(0,0,0,0,0, 1,0,0,0, 0,0,0, 0,1,16'h00A4));
        sample("br_n", O_BR, 1'b0);
        adv();
        drive(mk(0,0,0,0,0, 1,0,0,0, 0,0,0, 0,1,16'h1234));
        sample("br_n1", O_SQ, 1'b1);
        chk("br_n1.pc", 32'(bus.pc_redirect), 32'h00A4);
        adv();
        drive(zero);
        sample("br_n2", O_NORM, 1'b0);
        chk("br_n2.pc", 32'(bus.pc_redirect), 32'h00A4);
        adv();

        // Branch with simultaneous load-use: no stall
        drive(mk(1,2,1,0,0, 1,1,2,1, 0,0,0, 1,1,16'h0042));
        sample("brlu_n", O_BR, 1'b0);
        adv();
        drive(zero);
        sample("brlu_n1", O_SQ, 1'b1);
        chk("brlu_n1.pc", 32'(bus.pc_redirect), 32'h0042);
        adv();
        sample("brlu_n2", O_NORM, 1'b0);
        adv();

        // Reset on the second MEM_WAIT cycle
        drive(mem);
        sample("rmw_entry", O_STALL, 1'b0);
        adv();
        sample("rmw_wait1", O_STALL, 1'b0);
        adv();
        rst = 1'b1;
        sample("rmw_rst", O_RST, 1'b0);
        adv();
        rst = 1'b0;
        drive(zero);
        sample("rmw_after", O_NORM, 1'b0);
        chk("rmw_after.terr", 32'(bus.timeout_err), 32'h0);
        adv();

        // Miss that never completes
        drive(mem);
        sample("to_entry", O_STALL, 1'b0);
        adv();
        drive(zero);
`ifdef PIPE_MEM_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            sample($sformatf("to_wait%0d", k), O_STALL, 1'b0);
            chk($sformatf("to_wait%0d.terr", k), 32'(bus.timeout_err), 32'h0);
            adv();
        end
        sample("to_idle", O_NORM, 1'b0);
        chk("to_idle.terr", 32'(bus.timeout_err), 32'h1);
        adv();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("to_sticky%0d", k), 32'(bus.timeout_err), 32'h1);
            adv();
        end
        rst = 1'b1;
        adv();
        rst = 1'b0;
        @(negedge clk);
        chk("to_cleared", 32'(bus.timeout_err), 32'h0);
        adv();
`else
        for (int k = 1; k <= 12; k++) begin
            sample($sformatf("nto_wait%0d", k), O_STALL, 1'b0);
            chk($sformatf("nto_wait%0d.terr", k), 32'(bus.timeout_err), 32'h0);
            adv();
        end
        drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 1,0,16'h0));
        sample("nto_release", O_NORM, 1'b0);
        adv();
        drive(zero);
`endif

        // Randomized phase against the reference model
        m_wait = 0; m_squash = 0; m_rv = 0; m_terr = 0; m_wcnt = 0; m_rpc = '0;
        for (int i = 0; i < 3000; i++) begin
            in_t        x;
            bit         r, stall, tmo, branch, lu, lu_eff;
            logic [9:0] eo;
            logic [1:0] f0, f1;
            x = mk($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 1'($urandom),
                   3'($urandom_range(0, 3)), 1'($urandom),
                   $urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom_range(0, 3)),
                   $urandom_range(0, 9) < 3,
                   1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, 16'($urandom));
            r = (i == 0) || ($urandom_range(0, 99) == 0);
            rst = r;
            drive(x);

            stall  = (!m_wait && x.av && x.amem && !x.dcd) || (m_wait && !x.dcd);
            tmo    = TO_EN && m_wait && !x.dcd && (m_wcnt == int'(MEM_TIMEOUT) - 1);
            branch = !stall && x.av && x.br && !m_squash;
            lu     = x.dv && x.av && x.amem && x.awr &&
                     ((x.u0 && x.aad == x.s0) || (x.u1 && x.aad == x.s1));
            lu_eff = lu && !stall && !branch;
            f0     = ref_fwd(x, x.u0, x.s0);
            f1     = ref_fwd(x, x.u1, x.s1);
            if (r) begin
                eo = O_RST;
                branch = 0;
                tmo = 0;
            end else if (stall) begin
                eo = {6'b000001, f0, f1};
            end else begin
                eo = {!lu_eff, !lu_eff, 1'b1, branch || m_squash, branch || lu_eff, 1'b0, f0, f1};
            end

            @(negedge clk);
            chk($sformatf("rnd%0d.o", i), 32'(outs()), 32'(eo));
            chk($sformatf("rnd%0d.rv", i), 32'(bus.pc_redirect_valid), 32'(m_rv));
            chk($sformatf("rnd%0d.pc", i), 32'(bus.pc_redirect), 32'(m_rpc));
            chk($sformatf("rnd%0d.terr", i), 32'(bus.timeout_err), 32'(m_terr));

            if (r) begin
                m_wait = 0; m_squash = 0; m_rv = 0; m_terr = 0; m_wcnt = 0; m_rpc = '0;
            end else begin
                m_wcnt   = (m_wait && !x.dcd) ? m_wcnt + 1 : 0;
                m_wait   = stall && !tmo;
                m_squash = branch;
                m_rv     = branch;
                if (branch) m_rpc = x.tgt;
                m_terr   = m_terr || tmo;
            end
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
